// File: rtl/mastermind_round_sched_if.sv
// Handshake and result bundle between the Mastermind top level and the round scheduler.
// The master side is the top level; the slave side is mastermind_round_sched.
interface mastermind_round_sched_if #(
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic             guess_done;
  logic [2:0]       red;
  logic [2:0]       white;
  logic             guess_en;
  logic             reset_score;
  logic             compare;
  logic [1:0]       compare_i;
  logic             score_valid;
  logic [2:0]       red_q;
  logic [2:0]       white_q;
  logic [CNT_W-1:0] round;
  logic             win;
  logic             lose;

  modport master (
    output start, guess_done, red, white,
    input  guess_en, reset_score, compare, compare_i, score_valid,
    input  red_q, white_q, round, win, lose
  );

  modport slave (
    input  start, guess_done, red, white,
    output guess_en, reset_score, compare, compare_i, score_valid,
    output red_q, white_q, round, win, lose
  );
endinterface

// File: rtl/mastermind_round_sched.sv
// Mastermind round scheduler: clears and steps the peg scorer once per guess, latches the
// result, counts guesses and declares win/loss. Macro MM_GUESS_LIMIT_EN enables loss detection.
module mastermind_round_sched #(
  parameter int unsigned MAX_GUESSES = 8,
  parameter int unsigned CNT_W       = 4
) (
  input logic                      clk,
  input logic                      resetn,
  mastermind_round_sched_if.slave  sched_io
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StArmed  = 4'd1;
  localparam logic [3:0] StClr    = 4'd2;
  localparam logic [3:0] StCmp0   = 4'd3;
  localparam logic [3:0] StCmp1   = 4'd4;
  localparam logic [3:0] StCmp2   = 4'd5;
  localparam logic [3:0] StCmp3   = 4'd6;
  localparam logic [3:0] StSettle = 4'd7;
  localparam logic [3:0] StEval   = 4'd8;
  localparam logic [3:0] StWin    = 4'd9;
  localparam logic [3:0] StLose   = 4'd10;

  localparam logic [CNT_W-1:0] RoundMax   = '1;
  localparam logic [CNT_W-1:0] LimitRound = CNT_W'(MAX_GUESSES);

  logic [3:0]       state_q, state_d;
  logic [2:0]       red_lat_q, red_lat_d;
  logic [2:0]       white_lat_q, white_lat_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic             limit_hit;

`ifdef MM_GUESS_LIMIT_EN
  assign limit_hit = (round_q == LimitRound);
`else
  // Unlimited guesses: the limit compare is kept but never allowed to end the game.
  assign limit_hit = 1'b0 & (round_q == LimitRound);
`endif

  always_comb begin
    state_d     = state_q;
    red_lat_d   = red_lat_q;
    white_lat_d = white_lat_q;
    round_d     = round_q;
    case (state_q)
      StIdle:   if (sched_io.start) state_d = StArmed;
      StArmed:  if (sched_io.guess_done) state_d = StClr;
      StClr:    state_d = StCmp0;
      StCmp0:   state_d = StCmp1;
      StCmp1:   state_d = StCmp2;
      StCmp2:   state_d = StCmp3;
      StCmp3:   state_d = StSettle;
      StSettle: begin
        // Scorer count is stable here; capture it on the way into EVAL.
        state_d     = StEval;
        red_lat_d   = sched_io.red;
        white_lat_d = sched_io.white;
        if (round_q != RoundMax) round_d = round_q + 1'b1;
      end
      StEval: begin
        if (red_lat_q == 3'd4) state_d = StWin;
        else if (limit_hit)    state_d = StLose;
        else                   state_d = StArmed;
      end
      StWin, StLose: begin
        if (sched_io.start) begin
          state_d     = StArmed;
          red_lat_d   = '0;
          white_lat_d = '0;
          round_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      red_lat_q   <= '0;
      white_lat_q <= '0;
      round_q     <= '0;
    end else begin
      state_q     <= state_d;
      red_lat_q   <= red_lat_d;
      white_lat_q <= white_lat_d;
      round_q     <= round_d;
    end
  end

  always_comb begin
    sched_io.compare_i = 2'd0;
    case (state_q)
      StCmp1:  sched_io.compare_i = 2'd1;
      StCmp2:  sched_io.compare_i = 2'd2;
      StCmp3:  sched_io.compare_i = 2'd3;
      default: sched_io.compare_i = 2'd0;
    endcase
  end

  assign sched_io.guess_en    = (state_q == StArmed);
  assign sched_io.reset_score = (state_q == StClr);
  assign sched_io.compare     = (state_q == StCmp0) || (state_q == StCmp1) ||
                                (state_q == StCmp2) || (state_q == StCmp3);
  assign sched_io.score_valid = (state_q == StEval);
  assign sched_io.red_q       = red_lat_q;
  assign sched_io.white_q     = white_lat_q;
  assign sched_io.round       = round_q;
  assign sched_io.win         = (state_q == StWin);
`ifdef MM_GUESS_LIMIT_EN
  assign sched_io.lose        = (state_q == StLose);
`else
  assign sched_io.lose        = 1'b0;
`endif

endmodule
